// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per producer (ALU, LSU), round-robin
// broadcast of one result per cycle onto a registered CDB.
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              alu_valid_in,
  input  logic [ROB_W-1:0]  alu_reorder_in,
  input  logic [DATA_W-1:0] alu_value_in,
  output logic              alu_ready_out,
  input  logic              lsu_valid_in,
  input  logic [ROB_W-1:0]  lsu_reorder_in,
  input  logic [DATA_W-1:0] lsu_value_in,
  output logic              lsu_ready_out,
  output logic              cdb_enable_out,
  output logic [ROB_W-1:0]  cdb_reorder_out,
  output logic [DATA_W-1:0] cdb_value_out,
  output logic              cdb_src_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROB_W + DATA_W;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // index 0 = ALU, index 1 = LSU
  logic [ENT_W-1:0] r_mem  [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_head [2];
  logic [PTR_W-1:0] r_tail [2];
  logic [CNT_W-1:0] r_cnt  [2];
  logic             r_last_grant;

  logic [ENT_W-1:0] w_in [2];
  logic [1:0]       w_valid;
  logic [1:0]       w_ne;
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic             w_run;

  assign w_run = rdy_in && !flush_in;

  always_comb begin
    w_in[0]  = {alu_reorder_in, alu_value_in};
    w_in[1]  = {lsu_reorder_in, lsu_value_in};
    w_valid  = {lsu_valid_in, alu_valid_in};
    w_ne     = '0;
    w_ready  = '0;
    w_push   = '0;
    for (int s = 0; s < 2; s++) begin
      w_ne[s]    = (r_cnt[s] != '0);
      // A full FIFO stays not-ready even if it is popped this cycle.
      w_ready[s] = w_run && (r_cnt[s] != CNT_W'(FIFO_DEPTH));
      w_push[s]  = w_valid[s] && w_ready[s];
    end
    w_pop[0] = w_run && w_ne[0] && (!w_ne[1] || (r_last_grant == SRC_LSU));
    w_pop[1] = w_run && w_ne[1] && (!w_ne[0] || (r_last_grant == SRC_ALU));
  end

  assign alu_ready_out = w_ready[0];
  assign lsu_ready_out = w_ready[1];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        r_head[s] <= '0;
        r_tail[s] <= '0;
        r_cnt[s]  <= '0;
      end
      r_last_grant    <= SRC_LSU;
      cdb_enable_out  <= 1'b0;
      cdb_reorder_out <= '0;
      cdb_value_out   <= '0;
      cdb_src_out     <= 1'b0;
    end else if (flush_in) begin
      for (int s = 0; s < 2; s++) begin
        r_head[s] <= '0;
        r_tail[s] <= '0;
        r_cnt[s]  <= '0;
      end
      cdb_enable_out <= 1'b0;
    end else if (!rdy_in) begin
      // Drop enable so a stale broadcast is not consumed again after the stall.
      cdb_enable_out <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) begin
          r_mem[s][r_tail[s]] <= w_in[s];
          r_tail[s]           <= r_tail[s] + 1'b1;
        end
        if (w_pop[s]) r_head[s] <= r_head[s] + 1'b1;
        if (w_push[s] && !w_pop[s])      r_cnt[s] <= r_cnt[s] + 1'b1;
        else if (w_pop[s] && !w_push[s]) r_cnt[s] <= r_cnt[s] - 1'b1;
      end
      if (w_pop[0]) begin
        cdb_enable_out                   <= 1'b1;
        {cdb_reorder_out, cdb_value_out} <= r_mem[0][r_head[0]];
        cdb_src_out                      <= SRC_ALU;
        r_last_grant                     <= SRC_ALU;
      end else if (w_pop[1]) begin
        cdb_enable_out                   <= 1'b1;
        {cdb_reorder_out, cdb_value_out} <= r_mem[1][r_head[1]];
        cdb_src_out                      <= SRC_LSU;
        r_last_grant                     <= SRC_LSU;
      end else begin
        cdb_enable_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcast into a scoreboard that is popped and compared after the edge.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        alu_valid_in = 1'b0;
  logic [3:0]  alu_reorder_in = '0;
  logic [31:0] alu_value_in = '0;
  logic        alu_ready_out;
  logic        lsu_valid_in = 1'b0;
  logic [3:0]  lsu_reorder_in = '0;
  logic [31:0] lsu_value_in = '0;
  logic        lsu_ready_out;
  logic        cdb_enable_out;
  logic [3:0]  cdb_reorder_out;
  logic [31:0] cdb_value_out;
  logic        cdb_src_out;

  cdb_arbiter #(.DATA_W(32), .ROB_W(4), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .alu_valid_in(alu_valid_in), .alu_reorder_in(alu_reorder_in),
    .alu_value_in(alu_value_in), .alu_ready_out(alu_ready_out),
    .lsu_valid_in(lsu_valid_in), .lsu_reorder_in(lsu_reorder_in),
    .lsu_value_in(lsu_value_in), .lsu_ready_out(lsu_ready_out),
    .cdb_enable_out(cdb_enable_out), .cdb_reorder_out(cdb_reorder_out),
    .cdb_value_out(cdb_value_out), .cdb_src_out(cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [35:0] m_alu_q[$];
  logic [35:0] m_lsu_q[$];
  logic        m_last;
  logic        m_en;
  logic        m_src;
  logic [3:0]  m_tag;
  logic [31:0] m_val;
  logic [37:0] sb[$];

  logic a_acc, l_acc;
  logic lsu_full_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_alu_q.delete();
    m_lsu_q.delete();
    m_last = 1'b1;
    m_en = 1'b0; m_src = 1'b0; m_tag = '0; m_val = '0;
  endtask

  // Called at a negedge: drive inputs, check readies, predict, clock, compare.
  task automatic step(input logic av, input logic [3:0] at, input logic [31:0] avl,
                      input logic lv, input logic [3:0] lt, input logic [31:0] lvl,
                      input logic rdy, input logic fl, input logic rs);
    logic exp_ar, exp_lr, ane, lne;
    logic [37:0] expv, got;
    alu_valid_in = av; alu_reorder_in = at; alu_value_in = avl;
    lsu_valid_in = lv; lsu_reorder_in = lt; lsu_value_in = lvl;
    rdy_in = rdy; flush_in = fl; rst_in = rs;
    #1;
    exp_ar = rdy && !fl && (m_alu_q.size() < 4);
    exp_lr = rdy && !fl && (m_lsu_q.size() < 4);
    check("alu_ready", 64'(alu_ready_out), 64'(exp_ar));
    check("lsu_ready", 64'(lsu_ready_out), 64'(exp_lr));
    if (!exp_lr && rs) lsu_full_seen = lsu_full_seen | (rdy && !fl);
    a_acc = av && exp_ar && rs;
    l_acc = lv && exp_lr && rs;
    if (!rs) begin
      model_reset();
    end else if (fl) begin
      m_alu_q.delete();
      m_lsu_q.delete();
      m_en = 1'b0;
    end else if (!rdy) begin
      m_en = 1'b0;
    end else begin
      ane = m_alu_q.size() > 0;
      lne = m_lsu_q.size() > 0;
      if (ane && (!lne || m_last)) begin
        {m_tag, m_val} = m_alu_q.pop_front();
        m_en = 1'b1; m_src = 1'b0; m_last = 1'b0;
      end else if (lne) begin
        {m_tag, m_val} = m_lsu_q.pop_front();
        m_en = 1'b1; m_src = 1'b1; m_last = 1'b1;
      end else begin
        m_en = 1'b0;
      end
      if (a_acc) m_alu_q.push_back({at, avl});
      if (l_acc) m_lsu_q.push_back({lt, lvl});
    end
    sb.push_back({m_en, m_src, m_tag, m_val});
    @(posedge clk_in);
    #1;
    got  = {cdb_enable_out, cdb_src_out, cdb_reorder_out, cdb_value_out};
    expv = sb.pop_front();
    check("cdb_bcast", 64'(got), 64'(expv));
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    int ai, li;
    lsu_full_seen = 1'b0;
    rst_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    model_reset();

    // single ALU result, then bus goes idle
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 4'd3, 32'h11, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("t1_direct", 64'({cdb_enable_out, cdb_reorder_out, cdb_value_out, cdb_src_out}),
          64'({1'b1, 4'd3, 32'h11, 1'b0}));
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("t1_idle_en", 64'(cdb_enable_out), 64'(0));

    // both push every cycle: strict alternation
    step(1, 4'd1, 32'hA1, 1, 4'd9,  32'hB9, 1, 0, 1);
    step(1, 4'd2, 32'hA2, 1, 4'd10, 32'hBA, 1, 0, 1);
    step(1, 4'd3, 32'hA3, 1, 4'd11, 32'hBB, 1, 0, 1);
    idle(7);

    // both flood; producers hold data until accepted
    ai = 0; li = 0;
    for (int c = 0; c < 28; c++) begin
      step(ai < 12, 4'(ai), 32'h100 + 32'(ai), li < 8, 4'(li + 4), 32'h200 + 32'(li), 1, 0, 1);
      if (a_acc) ai++;
      if (l_acc) li++;
    end
    idle(14);
    check("t3_lsu_full_seen", 64'(lsu_full_seen), 64'(1));
    check("t3_alu_all_sent", 64'(ai), 64'(12));
    check("t3_lsu_all_sent", 64'(li), 64'(8));

    // queue entries then stall three cycles, with valids held high
    step(1, 4'd1, 32'hC1, 1, 4'd5, 32'hD5, 1, 0, 1);
    step(1, 4'd2, 32'hC2, 1, 4'd6, 32'hD6, 1, 0, 1);
    step(0, 0, 0, 1, 4'd7, 32'hD7, 1, 0, 1);
    step(1, 4'd8, 32'hC8, 1, 4'd12, 32'hDC, 0, 0, 1);
    step(1, 4'd8, 32'hC8, 1, 4'd12, 32'hDC, 0, 0, 1);
    step(1, 4'd8, 32'hC8, 1, 4'd12, 32'hDC, 0, 0, 1);
    idle(8);

    // flush with a same-cycle ALU push
    step(1, 4'd1, 32'hE1, 1, 4'd2, 32'hF2, 1, 0, 1);
    step(1, 4'd3, 32'hE3, 1, 4'd4, 32'hF4, 1, 0, 1);
    step(1, 4'd5, 32'hE5, 0, 0, 0, 1, 1, 1);
    check("t5_en_after_flush", 64'(cdb_enable_out), 64'(0));
    idle(4);

    // reset while busy, then a tie goes to the ALU
    step(1, 4'd1, 32'h31, 1, 4'd2, 32'h42, 1, 0, 1);
    step(1, 4'd3, 32'h33, 1, 4'd4, 32'h44, 1, 0, 1);
    step(1, 4'd5, 32'h35, 1, 4'd6, 32'h46, 1, 0, 0);
    check("t6_outs_zero", 64'({cdb_enable_out, cdb_reorder_out, cdb_value_out, cdb_src_out}), 64'(0));
    step(1, 4'd0, 32'h77, 1, 4'd9, 32'h99, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("t6_tie_alu", 64'({cdb_enable_out, cdb_src_out, cdb_reorder_out, cdb_value_out}),
          64'({1'b1, 1'b0, 4'd0, 32'h77}));
    idle(3);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
